// File: rtl/mux_stream_rr_pkg.sv
// Shared constants for the stream mux: mode encoding and statistics counter width.
package mux_pkg;

  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   STATS_CNT_W = 16;

endpackage

// File: rtl/mux_stream_rr_if.sv
// Bundle of the per-channel input streams, the select controls and the output stream.
interface mux_stream_rr_if #(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_stream_rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  int               cand;
  logic [SEL_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand     = (int'(ptr) + k) % NUM_CH;
      cand_idx = SEL_W'(cand);
      if (!gnt_vld && req[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    gnt[gnt_idx] = gnt_vld;
  end

endmodule

// File: rtl/mux_stream_rr.sv
// Registered N-to-1 stream mux with fixed-select or round-robin arbitration.
// Defining MUX_STREAM_RR_STATS_EN adds the xfer_cnt output-transfer counter port.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic           clk,
  input  logic           rst,
  mux_stream_rr_if.slave bus
`ifdef MUX_STREAM_RR_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] xfer_cnt
`endif
);

  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;

  logic [NUM_CH-1:0] rr_gnt, fix_gnt, grant;
  logic [SEL_W-1:0]  rr_idx, gnt_idx;
  logic              rr_vld, fix_vld, gnt_vld, sel_ok, rr_mode;
  logic              load_en, in_xfer, out_xfer;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Out-of-range selects (non-power-of-2 NUM_CH) must never grant.
  assign sel_ok  = int'(bus.sel) < NUM_CH;
  assign fix_vld = sel_ok && bus.in_valid[bus.sel];

  always_comb begin
    fix_gnt = '0;
    fix_gnt[bus.sel] = fix_vld;
  end

  assign rr_mode  = (bus.mode == MODE_RR);
  assign grant    = rr_mode ? rr_gnt : fix_gnt;
  assign gnt_idx  = rr_mode ? rr_idx : bus.sel;
  assign gnt_vld  = rr_mode ? rr_vld : fix_vld;

  assign load_en  = !out_valid_q || bus.out_ready;
  assign in_xfer  = load_en && gnt_vld && !rst;
  assign out_xfer = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_xfer ? grant : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      out_data_d  = bus.in_data[gnt_idx*DATA_W +: DATA_W];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (rr_mode) rr_ptr_d = gnt_idx;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MUX_STREAM_RR_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d    = out_xfer ? cnt_q + 1'b1 : cnt_q;
  assign xfer_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr: directed scenarios plus randomized traffic vs a reference model.
module tb_mux_stream_rr;
  import mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int N6 = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_stream_rr_if #(.NUM_CH(N),  .DATA_W(W)) bus  ();
  mux_stream_rr_if #(.NUM_CH(N6), .DATA_W(W)) bus6 ();

`ifdef MUX_STREAM_RR_STATS_EN
  logic [15:0] xfer_cnt, xfer_cnt6;
  mux_stream_rr #(.NUM_CH(N),  .DATA_W(W)) dut  (.clk(clk), .rst(rst), .bus(bus),  .xfer_cnt(xfer_cnt));
  mux_stream_rr #(.NUM_CH(N6), .DATA_W(W)) dut6 (.clk(clk), .rst(rst), .bus(bus6), .xfer_cnt(xfer_cnt6));
`else
  mux_stream_rr #(.NUM_CH(N),  .DATA_W(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mux_stream_rr #(.NUM_CH(N6), .DATA_W(W)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy of the output slot, last RR winner, queue of expected words.
  typedef struct {
    logic [W-1:0] data;
    int           ch;
  } word_t;

  word_t        sbq[$];
  word_t        mon_w;
  bit           m_valid;
  int           m_ptr;
  int           m_g;
  int           m_c;
  bit           m_load;
  logic [N-1:0] m_rdy;

  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = N - 1;
      sbq.delete();
      check("in_ready_in_reset", bus.in_ready, '0);
    end else begin
      m_g = -1;
      if (bus.mode == MODE_RR) begin
        for (int k = 1; k <= N; k++) begin
          m_c = (m_ptr + k) % N;
          if (m_g < 0 && bus.in_valid[m_c]) m_g = m_c;
        end
      end else if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
        m_g = int'(bus.sel);
      end
      m_load = !m_valid || bus.out_ready;
      m_rdy  = (m_load && m_g >= 0) ? (N'(1) << m_g) : '0;
      check("in_ready", bus.in_ready, m_rdy);
      check("out_valid", bus.out_valid, m_valid);
      if (m_load && m_g >= 0) begin
        sbq.push_back('{bus.in_data[m_g*W +: W], m_g});
        m_valid = 1'b1;
        if (bus.mode == MODE_RR) m_ptr = m_g;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: pops one expected word per output transfer.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: output word ch %0d data %0h with nothing expected", bus.out_ch, bus.out_data);
      end else begin
        mon_w = sbq.pop_front();
        check("sb_data", bus.out_data, mon_w.data);
        check("sb_ch", bus.out_ch, mon_w.ch);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [W-1:0] held;

  initial begin
    rst            = 1'b1;
    bus.in_data    = '0;
    bus.in_valid   = '0;
    bus.mode       = MODE_FIXED;
    bus.sel        = '0;
    bus.out_ready  = 1'b0;
    bus6.in_data   = '0;
    bus6.in_valid  = '0;
    bus6.mode      = MODE_FIXED;
    bus6.sel       = '0;
    bus6.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
`ifdef MUX_STREAM_RR_STATS_EN
    check("rst_xfer_cnt", xfer_cnt, 0);
`endif
    rst = 1'b0;

    // Fixed select of channel 3.
    bus.in_data        = {$urandom, $urandom};
    bus.in_data[3*W +: W] = 8'hA5;
    bus.sel            = 3'd3;
    bus.in_valid       = 8'h08;
    bus.out_ready      = 1'b1;
    #1 check("fixed_in_ready", bus.in_ready, 8'h08);
    tick();
    check("fixed_out_data", bus.out_data, 8'hA5);
    check("fixed_out_ch", bus.out_ch, 3);
    check("fixed_out_valid", bus.out_valid, 1);
    bus.in_valid = '0;
    tick();
    check("fixed_drain", bus.out_valid, 0);

    // Round-robin fairness from reset.
    do_reset();
    bus.mode      = MODE_RR;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    bus.in_data   = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rr_seq_ch", bus.out_ch, i % N);
      check("rr_seq_valid", bus.out_valid, 1);
      check("rr_seq_data", bus.out_data, bus.in_data[(i % N)*W +: W]);
    end

    // Backpressure holds channel 1 and freezes the pointer.
    bus.out_ready = 1'b0;
    held = bus.out_data;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_ch", bus.out_ch, 1);
      check("bp_out_data", bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_ch", bus.out_ch, 2);

    // Pointer survives a fixed-mode interlude.
    bus.mode = MODE_FIXED;
    bus.sel  = 3'd5;
    tick();
    check("fixed_interlude_ch", bus.out_ch, 5);
    bus.mode = MODE_RR;
    tick();
    check("rr_resume_ch", bus.out_ch, 3);

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_data", bus.out_data, 0);
    check("async_rst_ch", bus.out_ch, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
    tick();
    rst           = 1'b0;
    bus.mode      = MODE_RR;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_first_ch", bus.out_ch, 0);
    check("post_rst_valid", bus.out_valid, 1);

    // Out-of-range select on the six-channel instance.
    bus6.in_data  = {$urandom, $urandom};
    bus6.mode     = MODE_FIXED;
    bus6.sel      = 3'd7;
    bus6.in_valid = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("badsel_in_ready", bus6.in_ready, 0);
      check("badsel_out_valid", bus6.out_valid, 0);
    end
    bus6.sel = 3'd5;
    #1 check("sel5_in_ready", bus6.in_ready, 6'h20);
    tick();
    check("sel5_out_ch", bus6.out_ch, 5);
    check("sel5_out_data", bus6.out_data, bus6.in_data[5*W +: W]);
    bus6.in_valid = '0;

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.in_data   = {$urandom, $urandom};
      bus.in_valid  = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom & $urandom) : N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sel       = 3'($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
    end

`ifdef MUX_STREAM_RR_STATS_EN
    do_reset();
    check("stats_rst", xfer_cnt, 0);
    bus.mode      = MODE_FIXED;
    bus.sel       = '0;
    bus.in_valid  = 8'h01;
    bus.out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    check("stats_ffff", xfer_cnt, 16'hFFFF);
    bus.in_valid = '0;
    tick();
    check("stats_wrap", xfer_cnt, 16'h0000);
`endif

    bus.in_valid = '0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with a valid/ready handshake per input and on the output.
- Output is registered (one pipeline stage).
- Channel choice is either an externally driven select line (FIXED mode) or an internal round-robin arbiter (RR mode).
- Sits between multiple data producers and one shared consumer, e.g. a shared bus port or ALU operand path.

Parameters:
- NUM_CH, 8, number of input channels (2..64).
- DATA_W, 8, width of each channel's data word.
- SEL_W, $clog2(NUM_CH), width of the select and channel-id fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit is high in any cycle.
- mode  input  1  0 = FIXED (use sel), 1 = RR.
- sel  input  SEL_W  channel select, used in FIXED mode only.
- out_data  output  DATA_W  registered output data.
- out_ch  output  SEL_W  channel index of the word held in out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous, on rst high):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - rr_ptr = NUM_CH-1, so channel 0 has first priority after reset.
  - in_ready = 0 while rst is high.
- load_en = !out_valid | out_ready. The output register can accept a new word this cycle.
- Grant, combinational:
  - FIXED mode: grant channel sel if sel < NUM_CH and in_valid[sel]; otherwise no grant.
    - sel >= NUM_CH (non-power-of-2 NUM_CH) never grants and never raises in_ready.
  - RR mode: grant the first channel with in_valid set, searching rr_ptr+1, rr_ptr+2, ... and wrapping modulo NUM_CH. No valid channel means no grant.
- in_ready[i] = load_en & grant[i]. A transfer on input i is in_valid[i] & in_ready[i].
- On an input transfer:
  - out_data <= that channel's data, out_ch <= i, out_valid <= 1.
  - In RR mode only, rr_ptr <= i.
- On an output transfer (out_valid & out_ready) with no simultaneous input transfer: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous output and input transfer in the same cycle: the register reloads and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Latency: an input transfer at edge n is visible on out_data/out_valid after edge n.
- Backpressure: when out_valid = 1 and out_ready = 0:
  - all in_ready are 0;
  - out_data and out_ch are stable;
  - rr_ptr is frozen.
- Mode and sel changes are sampled combinationally at each arbitration. They never disturb a word already in the output register. rr_ptr keeps its value across FIXED periods.
- Input data is not checked. Producers must hold data stable while valid and not ready.

Optional Feature:
- Macro: MUX_STREAM_RR_STATS_EN.
- Defined: adds output port xfer_cnt [15:0].
  - Increments by 1 on every output transfer.
  - Wraps from 16'hFFFF to 0.
  - Reset value 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg:
  - mode constants MODE_FIXED = 1'b0, MODE_RR = 1'b1;
  - STATS_CNT_W = 16.
- Sub-module rr_arbiter:
  - parameter NUM_CH;
  - inputs req[NUM_CH], ptr[SEL_W];
  - outputs gnt (one-hot), gnt_idx, gnt_vld.
  - Purely combinational.
  - rr_ptr storage stays in mux_stream_rr.

Test Plan:
- Reset check: assert rst mid-stream with out_valid = 1 -> out_valid, out_data and out_ch go to 0 immediately, without waiting for a clock edge. After release in RR mode with all in_valid = 1, the first grant is channel 0.
- FIXED mode, NUM_CH = 8, DATA_W = 8: in_data ch3 = 8'hA5, sel = 3, in_valid = 8'h08, out_ready = 1 -> in_ready = 8'h08; next cycle out_data = 8'hA5, out_ch = 3, out_valid = 1.
- RR fairness: all in_valid = 8'hFF, out_ready = 1 for 10 cycles -> out_ch sequence 0,1,2,3,4,5,6,7,0,1 with out_valid continuously 1.
- Backpressure: out_valid = 1, out_ready = 0 for 4 cycles -> in_ready = 0, out_data stable, rr_ptr unchanged. On out_ready = 1, the next channel after the held one is granted.
- Invalid select: NUM_CH = 6, FIXED mode, sel = 7, in_valid = 6'h3F -> in_ready = 0, out_valid stays 0.
- Stats (MUX_STREAM_RR_STATS_EN defined): preload 65535 output transfers, then 1 more -> xfer_cnt = 16'hFFFF, then 16'h0000.
